// File: rtl/axi_traffic_gen.sv
// axi_traffic_gen: AXI4 master running one burst per command with address-derived data.
// Optional read-data compare is enabled by defining AXI_TG_RDCHECK_EN.
module axi_traffic_gen #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDR_WIDTH   = 16,
    parameter int          STRB_WIDTH   = DATA_WIDTH / 8,
    parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0000
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  start_w,
    input  logic                  start_r,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  cmd_err,
    output logic [15:0]           err_cnt,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [STRB_WIDTH-1:0] WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    localparam int LB = $clog2(STRB_WIDTH);
    localparam int OW = (LB > 0) ? LB : 1;

    typedef enum logic [2:0] {
        IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] base_q, addr_q, nxt_d, inc, wmask;
    logic [7:0]            len_q, beat_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q, rresp_q, resp_q, rmax;
    logic                  pend_q, busy_q, done_q, cerr_q;
    logic                  awvalid_q, arvalid_q, wvalid_q, wlast_q;
    logic                  bready_q, rready_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  bad_cmd, rlen_bad;

    // Replicated 32-bit word of address XOR seed.
    function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0]           w;
        logic [DATA_WIDTH-1:0] r;
        w = 32'(a) ^ PATTERN_SEED;
        for (int i = 0; i < DATA_WIDTH; i++) r[i] = w[i % 32];
        return r;
    endfunction

    // Lanes covered by a 2^s byte beat at address a, aligned down to s.
    function automatic logic [STRB_WIDTH-1:0] strb(input logic [ADDR_WIDTH-1:0] a,
                                                   input logic [2:0] s);
        logic [OW-1:0]         lo;
        logic [STRB_WIDTH-1:0] m;
        lo = a[OW-1:0];
        for (int i = 0; i < STRB_WIDTH; i++) m[i] = ((OW'(i) >> s) == (lo >> s));
        if (int'(s) >= LB) m = '1;
        return m;
    endfunction

    assign bad_cmd = (int'(cmd_size) > LB) || (cmd_burst == 2'd3) ||
                     (cmd_burst == 2'd2 && !(cmd_len == 8'd1 || cmd_len == 8'd3 ||
                                             cmd_len == 8'd7 || cmd_len == 8'd15));
    assign rmax     = (RRESP > rresp_q) ? RRESP : rresp_q;
    assign rlen_bad = RLAST != (beat_q == len_q);

    // Next beat address for the latched burst type.
    always_comb begin
        inc   = ADDR_WIDTH'(1) << size_q;
        wmask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        case (burst_q)
            2'd0:    nxt_d = addr_q;
            2'd2:    nxt_d = (addr_q & ~wmask) | ((addr_q + inc) & wmask);
            default: nxt_d = addr_q + inc;
        endcase
    end

    // Command acceptance and AXI burst sequencing.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            base_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            rresp_q   <= '0;
            resp_q    <= '0;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cerr_q    <= 1'b0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            done_q <= 1'b0;
            cerr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        pend_q    <= 1'b0;
                        addr_q    <= base_q;
                        arvalid_q <= 1'b1;
                        state_q   <= R_ADDR;
                    end else if (start_w || start_r) begin
                        if (bad_cmd) begin
                            cerr_q <= 1'b1;
                        end else begin
                            base_q  <= cmd_addr;
                            addr_q  <= cmd_addr;
                            len_q   <= cmd_len;
                            size_q  <= cmd_size;
                            burst_q <= cmd_burst;
                            busy_q  <= 1'b1;
                            if (start_w) begin
                                awvalid_q <= 1'b1;
                                pend_q    <= start_r;
                                state_q   <= W_ADDR;
                            end else begin
                                arvalid_q <= 1'b1;
                                state_q   <= R_ADDR;
                            end
                        end
                    end
                end
                W_ADDR: begin
                    if (AWREADY) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= (len_q == 8'd0);
                        wdata_q   <= pat(addr_q);
                        wstrb_q   <= strb(addr_q, size_q);
                        beat_q    <= '0;
                        state_q   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (WREADY) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= W_RESP;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            addr_q  <= nxt_d;
                            wdata_q <= pat(nxt_d);
                            wstrb_q <= strb(nxt_d, size_q);
                            wlast_q <= (beat_q + 8'd1 == len_q);
                        end
                    end
                end
                W_RESP: begin
                    if (BVALID) begin
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        resp_q   <= BRESP;
                        busy_q   <= pend_q;
                        state_q  <= IDLE;
                    end
                end
                R_ADDR: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat_q    <= '0;
                        rresp_q   <= '0;
                        state_q   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RVALID) begin
                        if (RLAST || beat_q == len_q) begin
                            rready_q <= 1'b0;
                            done_q   <= 1'b1;
                            resp_q   <= rlen_bad ? 2'b10 : rmax;
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            addr_q  <= nxt_d;
                            rresp_q <= rmax;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AXI_TG_RDCHECK_EN
    logic [15:0]           err_q, err_d;
    logic [STRB_WIDTH-1:0] rlane;
    logic [DATA_WIDTH-1:0] bmask;

    // Saturating count of read beats whose enabled lanes differ from the pattern.
    always_comb begin
        rlane = strb(addr_q, size_q);
        bmask = '0;
        for (int i = 0; i < STRB_WIDTH; i++) bmask[i*8 +: 8] = {8{rlane[i]}};
        err_d = err_q;
        if (state_q == R_DATA && RVALID && rready_q &&
            (|((RDATA ^ pat(addr_q)) & bmask)) && err_q != 16'hFFFF)
            err_d = err_q + 16'd1;
    end

    // Error counter register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) err_q <= '0;
        else          err_q <= err_d;
    end

    assign err_cnt = err_q;
`else
    wire unused_rdata = ^RDATA;
    assign err_cnt = '0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign done_resp = resp_q;
    assign cmd_err   = cerr_q;
    assign AWADDR    = base_q;
    assign AWLEN     = len_q;
    assign AWSIZE    = size_q;
    assign AWBURST   = burst_q;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign WLAST     = wlast_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = base_q;
    assign ARLEN     = len_q;
    assign ARSIZE    = size_q;
    assign ARBURST   = burst_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi_traffic_gen.sv
// tb_axi_traffic_gen: directed vector table plus corner sequences for axi_traffic_gen.
// Small AXI slave replays bench-supplied read data and responses.
module tb_axi_traffic_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_w = 1'b0, start_r = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic [1:0]  cmd_burst = '0;
    logic        busy, done, cmd_err;
    logic [1:0]  done_resp;
    logic [15:0] err_cnt;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, WLAST, WVALID, BREADY, ARVALID, RREADY;
    logic        AWREADY, ARREADY, BVALID, RLAST, RVALID;
    logic        WREADY = 1'b1;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
    logic [31:0] rd_tab [4];
    int          r_ovr = 0;
    int          r_left, r_idx;

    int n_vec = 0, n_bad = 0;

    logic [31:0] wd_q [$];
    logic [3:0]  ws_q [$];
    logic        wl_q [$];
    logic [15:0] aw_q [$], ar_q [$];
    logic        vs_q [$], rb_q [$];
    logic [1:0]  dn_q [$];

    typedef struct {
        bit             wr;
        logic [15:0]    addr;
        logic [7:0]     len;
        logic [2:0]     size;
        logic [1:0]     burst;
        bit             err;
        logic [3:0][31:0] d;
        logic [3:0][3:0]  s;
    } vec_t;

    vec_t tab [12];

    assign AWREADY = 1'b1;
    assign ARREADY = 1'b1;
    assign BRESP   = bresp_v;
    assign RRESP   = rresp_v;

    axi_traffic_gen dut (
        .ACLK(clk), .ARESETn(rst_n),
        .start_w(start_w), .start_r(start_r),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .busy(busy), .done(done), .done_resp(done_resp),
        .cmd_err(cmd_err), .err_cnt(err_cnt),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    // Slave: B after last W beat; R beats replayed from rd_tab.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BVALID <= 1'b0;
            RVALID <= 1'b0;
            RLAST  <= 1'b0;
            RDATA  <= '0;
            r_left <= 0;
            r_idx  <= 0;
        end else begin
            if (WVALID && WREADY && WLAST) BVALID <= 1'b1;
            else if (BVALID && BREADY)     BVALID <= 1'b0;
            if (ARVALID && ARREADY) begin
                r_left <= (r_ovr > 0) ? r_ovr : int'(ARLEN) + 1;
                r_idx  <= 0;
            end else if (r_left > 0 && (!RVALID || RREADY)) begin
                RVALID <= 1'b1;
                RDATA  <= rd_tab[r_idx];
                RLAST  <= (r_left == 1);
                r_idx  <= r_idx + 1;
                r_left <= r_left - 1;
            end else if (RVALID && RREADY) begin
                RVALID <= 1'b0;
                RLAST  <= 1'b0;
            end
        end
    end

    // Bus monitor.
    always @(posedge clk) begin
        if (rst_n) begin
            if (WVALID && WREADY) begin
                wd_q.push_back(WDATA);
                ws_q.push_back(WSTRB);
                wl_q.push_back(WLAST);
            end
            if (AWVALID && AWREADY) aw_q.push_back(AWADDR);
            if (ARVALID && ARREADY) ar_q.push_back(ARADDR);
            if (AWVALID || ARVALID) vs_q.push_back(1'b1);
            if (RVALID && RREADY)   rb_q.push_back(1'b1);
            if (done)               dn_q.push_back(done_resp);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit wr, input logic [15:0] a, input logic [7:0] l,
                                input logic [2:0] sz, input logic [1:0] b, input bit e,
                                input logic [31:0] d0, d1, d2, d3,
                                input logic [3:0] s0, s1, s2, s3);
        vec_t v;
        v.wr = wr; v.addr = a; v.len = l; v.size = sz; v.burst = b; v.err = e;
        v.d = {d3, d2, d1, d0};
        v.s = {s3, s2, s1, s0};
        return v;
    endfunction

    task automatic clr();
        wd_q.delete(); ws_q.delete(); wl_q.delete();
        aw_q.delete(); ar_q.delete(); vs_q.delete();
        rb_q.delete(); dn_q.delete();
    endtask

    task automatic issue(input bit w, input bit r, input logic [15:0] a,
                         input logic [7:0] l, input logic [2:0] sz, input logic [1:0] b);
        @(negedge clk);
        start_w = w; start_r = r;
        cmd_addr = a; cmd_len = l; cmd_size = sz; cmd_burst = b;
        @(negedge clk);
        start_w = 1'b0; start_r = 1'b0;
    endtask

    task automatic wait_end(output bit got);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done || cmd_err) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run(input bit w, input bit r, input logic [15:0] a, input logic [7:0] l,
                       input logic [2:0] sz, input logic [1:0] b, output bit cerr, output bit got);
        clr();
        issue(w, r, a, l, sz, b);
        cerr = cmd_err;
        wait_end(got);
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [1:0] dn0();
        return (dn_q.size() > 0) ? dn_q[0] : 2'bxx;
    endfunction

    initial begin
        vec_t v;
        bit   cerr, got, gap;
        int   nd, i1, ia;
        logic [15:0] exp_e;

        tab[0]  = mk(1, 16'h0005, 0, 2, 1, 0, 32'hA5A50005, 0, 0, 0, 4'hF, 0, 0, 0);
        tab[1]  = mk(0, 16'h0005, 0, 2, 1, 0, 32'hA5A50005, 0, 0, 0, 0, 0, 0, 0);
        tab[2]  = mk(1, 16'h8004, 3, 2, 1, 0, 32'hA5A58004, 32'hA5A58008,
                     32'hA5A5800C, 32'hA5A58010, 4'hF, 4'hF, 4'hF, 4'hF);
        tab[3]  = mk(0, 16'h8004, 3, 2, 1, 0, 32'hA5A58004, 32'hA5A58008,
                     32'hA5A5800C, 32'hA5A58010, 0, 0, 0, 0);
        tab[4]  = mk(1, 16'h0038, 3, 2, 2, 0, 32'hA5A50038, 32'hA5A5003C,
                     32'hA5A50030, 32'hA5A50034, 4'hF, 4'hF, 4'hF, 4'hF);
        tab[5]  = mk(0, 16'h0038, 3, 2, 2, 0, 32'hA5A50038, 32'hA5A5003C,
                     32'hA5A50030, 32'hA5A50034, 0, 0, 0, 0);
        tab[6]  = mk(1, 16'h0038, 2, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tab[7]  = mk(1, 16'h0041, 3, 0, 1, 0, 32'hA5A50041, 32'hA5A50042,
                     32'hA5A50043, 32'hA5A50044, 4'b0010, 4'b0100, 4'b1000, 4'b0001);
        tab[8]  = mk(0, 16'h0040, 0, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tab[9]  = mk(1, 16'h0040, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tab[10] = mk(1, 16'h0020, 1, 2, 0, 0, 32'hA5A50020, 32'hA5A50020,
                     0, 0, 4'hF, 4'hF, 0, 0);
        tab[11] = mk(1, 16'h0012, 1, 1, 1, 0, 32'hA5A50012, 32'hA5A50014,
                     0, 0, 4'b1100, 4'b0011, 0, 0);

        repeat (3) @(negedge clk);
        chk("reset valids", {AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY}, 0);
        chk("reset status", {busy, done, cmd_err, done_resp, err_cnt}, 0);
        chk("reset buses", {AWADDR, ARADDR, WDATA, WSTRB}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            v = tab[i];
            for (int b = 0; b < 4; b++) rd_tab[b] = v.d[b];
            run(v.wr, !v.wr, v.addr, v.len, v.size, v.burst, cerr, got);
            if (v.err) begin
                chk($sformatf("v%0d cmd_err", i), cerr, 1);
                chk($sformatf("v%0d no valid", i), vs_q.size(), 0);
                chk($sformatf("v%0d no done", i), dn_q.size(), 0);
            end else begin
                chk($sformatf("v%0d ended", i), got, 1);
                chk($sformatf("v%0d done_resp", i), {30'd0, dn0(), 30'(dn_q.size())}, {32'd0, 32'd1});
                if (v.wr) begin
                    chk($sformatf("v%0d awaddr", i), aw_q.size() > 0 ? aw_q[0] : 16'hxxxx, v.addr);
                    chk($sformatf("v%0d beats", i), wd_q.size(), int'(v.len) + 1);
                    for (int b = 0; b <= int'(v.len) && b < wd_q.size(); b++) begin
                        chk($sformatf("v%0d wdata%0d", i, b), wd_q[b], v.d[b]);
                        chk($sformatf("v%0d wstrb%0d", i, b), ws_q[b], v.s[b]);
                        chk($sformatf("v%0d wlast%0d", i, b), wl_q[b], b == int'(v.len));
                    end
                end else begin
                    chk($sformatf("v%0d araddr", i), ar_q.size() > 0 ? ar_q[0] : 16'hxxxx, v.addr);
                    chk($sformatf("v%0d rbeats", i), rb_q.size(), int'(v.len) + 1);
                    chk($sformatf("v%0d err_cnt", i), err_cnt, 0);
                end
            end
        end

        // Simultaneous write and read: read follows the write's done by one cycle.
        rd_tab[0] = 32'hA5A50100; rd_tab[1] = 32'hA5A50104;
        clr();
        issue(1, 1, 16'h0100, 1, 2, 1);
        nd = 0; gap = 0; i1 = -1; ia = -1;
        for (int c = 0; c < 300; c++) begin
            if (ARVALID && ia < 0) ia = c;
            if (done) begin
                nd++;
                if (nd == 1) i1 = c;
            end
            if (nd == 2) break;
            if (!busy) gap = 1;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("dual done count", nd, 2);
        chk("dual busy gap", gap, 0);
        chk("dual ar after done", ia, i1 + 1);
        chk("dual wbeats", wd_q.size(), 2);
        chk("dual wdata1", wd_q.size() > 1 ? wd_q[1] : 32'hx, 32'hA5A50104);
        chk("dual rbeats", rb_q.size(), 2);

        // W backpressure: data held while WREADY is low.
        clr();
        issue(1, 0, 16'h0200, 3, 2, 1);
        for (int c = 0; c < 100 && wd_q.size() < 1; c++) @(negedge clk);
        WREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp hold%0d", k), {WVALID, WDATA}, {1'b1, 32'hA5A50204});
            @(negedge clk);
        end
        WREADY = 1'b1;
        wait_end(got);
        repeat (3) @(negedge clk);
        chk("bp ended", got, 1);
        chk("bp beats", wd_q.size(), 4);
        chk("bp last data", wd_q.size() > 3 ? wd_q[3] : 32'hx, 32'hA5A5020C);
        chk("bp wlast", wl_q.size() > 3 ? {wl_q[2], wl_q[3]} : 2'bxx, 2'b01);

        // Write response and read response codes.
        bresp_v = 2'b11;
        run(1, 0, 16'h0000, 0, 2, 1, cerr, got);
        chk("bresp", dn0(), 2'b11);
        bresp_v = 2'b00;
        rresp_v = 2'b01;
        rd_tab[0] = 32'hA5A50008;
        run(0, 1, 16'h0008, 0, 2, 1, cerr, got);
        chk("rresp", dn0(), 2'b01);
        rresp_v = 2'b00;

        // Early RLAST on a 4-beat read.
        r_ovr = 2;
        rd_tab[0] = 32'hA5A50400; rd_tab[1] = 32'hA5A50404;
        run(0, 1, 16'h0400, 3, 2, 1, cerr, got);
        chk("early rlast resp", dn0(), 2'b10);
        chk("early rlast beats", rb_q.size(), 2);
        r_ovr = 0;

        // Read data that does not match the pattern.
        rd_tab[0] = 32'hDEADBEEF;
        run(0, 1, 16'h0010, 0, 2, 1, cerr, got);
`ifdef AXI_TG_RDCHECK_EN
        exp_e = 16'd1;
`else
        exp_e = 16'd0;
`endif
        chk("bad read err_cnt", err_cnt, exp_e);

        // Reset in the middle of a read.
        rd_tab[0] = 32'hA5A50300; rd_tab[1] = 32'hA5A50304;
        rd_tab[2] = 32'hA5A50308; rd_tab[3] = 32'hA5A5030C;
        clr();
        issue(0, 1, 16'h0300, 3, 2, 1);
        for (int c = 0; c < 100 && rb_q.size() < 1; c++) @(negedge clk);
        chk("mid read reached", rb_q.size(), 1);
        rst_n = 1'b0;
        #1;
        chk("rst valids", {AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY}, 0);
        chk("rst status", {busy, done, cmd_err, done_resp, err_cnt}, 0);
        chk("rst buses", {AWADDR, ARADDR, WDATA, WSTRB}, 0);
        dn_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst no done", dn_q.size(), 0);
        run(1, 0, 16'h0005, 0, 2, 1, cerr, got);
        chk("post rst data", wd_q.size() > 0 ? wd_q[0] : 32'hx, 32'hA5A50005);
        chk("post rst resp", {dn_q.size() == 1, dn0()}, {1'b1, 2'b00});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
